// File: rtl/morse_stream_decoder_pkg.sv
// Shared Morse decoder types: symbol codes, ASCII constants, FSM state and the
// letter/digit lookup table keyed by {len, pattern} (pattern LSB = newest element, 1 = dash).
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'b10;
  localparam logic [1:0] SYM_DASH = 2'b11;
  localparam logic [1:0] SYM_EOL  = 2'b01;
  localparam logic [1:0] SYM_EOW  = 2'b00;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_t;

  // Key fields are sized for the largest legal MAX_ELEMS (8).
  typedef struct packed {
    logic [3:0] len;
    logic [7:0] pat;
    logic [7:0] ascii;
  } lut_entry_t;

  localparam int N_BASE = 36;

  localparam lut_entry_t BASE_TABLE [N_BASE] = '{
    {4'd2, 8'b01,    8'h41}, {4'd4, 8'b1000,  8'h42}, {4'd4, 8'b1010,  8'h43},
    {4'd3, 8'b100,   8'h44}, {4'd1, 8'b0,     8'h45}, {4'd4, 8'b0010,  8'h46},
    {4'd3, 8'b110,   8'h47}, {4'd4, 8'b0000,  8'h48}, {4'd2, 8'b00,    8'h49},
    {4'd4, 8'b0111,  8'h4A}, {4'd3, 8'b101,   8'h4B}, {4'd4, 8'b0100,  8'h4C},
    {4'd2, 8'b11,    8'h4D}, {4'd2, 8'b10,    8'h4E}, {4'd3, 8'b111,   8'h4F},
    {4'd4, 8'b0110,  8'h50}, {4'd4, 8'b1101,  8'h51}, {4'd3, 8'b010,   8'h52},
    {4'd3, 8'b000,   8'h53}, {4'd1, 8'b1,     8'h54}, {4'd3, 8'b001,   8'h55},
    {4'd4, 8'b0001,  8'h56}, {4'd3, 8'b011,   8'h57}, {4'd4, 8'b1001,  8'h58},
    {4'd4, 8'b1011,  8'h59}, {4'd4, 8'b1100,  8'h5A},
    {4'd5, 8'b11111, 8'h30}, {4'd5, 8'b01111, 8'h31}, {4'd5, 8'b00111, 8'h32},
    {4'd5, 8'b00011, 8'h33}, {4'd5, 8'b00001, 8'h34}, {4'd5, 8'b00000, 8'h35},
    {4'd5, 8'b10000, 8'h36}, {4'd5, 8'b11000, 8'h37}, {4'd5, 8'b11100, 8'h38},
    {4'd5, 8'b11110, 8'h39}
  };

endpackage

// File: rtl/morse_stream_decoder_if.sv
// Symbol-in / character-out handshake bundle of the Morse decoder.
// slave = decoder side, master = symbol producer and text sink side.
interface morse_stream_decoder_if #(
  parameter int CNT_W = 8
);
  logic             sym_valid;
  logic             sym_ready;
  logic [1:0]       sym;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       ascii_out;
  logic             out_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output sym_valid, sym, out_ready,
    input  sym_ready, out_valid, ascii_out, out_err, err_count
  );

  modport slave (
    input  sym_valid, sym, out_ready,
    output sym_ready, out_valid, ascii_out, out_err, err_count
  );
endinterface

// File: rtl/morse_stream_decoder_lut.sv
// Combinational {len, pattern} -> ASCII lookup, zero latency, no handshake.
// MORSE_PUNCT_EN adds '.', ',' and '?' (needs MAX_ELEMS >= 6).
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_ELEMS = 5
) (
  input  logic [$clog2(MAX_ELEMS+1)-1:0] i_len,
  input  logic [MAX_ELEMS-1:0]           i_pattern,
  output logic [7:0]                     o_ascii,
  output logic                           o_hit
);

  if (MAX_ELEMS < 5 || MAX_ELEMS > 8) begin : g_bad_max_elems
    $error("morse_lut: MAX_ELEMS must be within 5..8");
  end

`ifdef MORSE_PUNCT_EN
  localparam int N_PUNCT = 3;
  localparam lut_entry_t PUNCT_TABLE [N_PUNCT] = '{
    {4'd6, 8'b010101, 8'h2E},
    {4'd6, 8'b110011, 8'h2C},
    {4'd6, 8'b001100, 8'h3F}
  };

  if (MAX_ELEMS < 6) begin : g_punct_too_short
    $error("morse_lut: MORSE_PUNCT_EN needs MAX_ELEMS >= 6");
  end
`endif

  logic [3:0] w_len;
  logic [7:0] w_pat;

  assign w_len = 4'(i_len);
  assign w_pat = 8'(i_pattern);

  // Keys are unique, so at most one entry can match.
  always_comb begin
    o_ascii = ASCII_NUL;
    o_hit   = 1'b0;
    for (int i = 0; i < N_BASE; i++) begin
      if (BASE_TABLE[i].len == w_len && BASE_TABLE[i].pat == w_pat) begin
        o_ascii = BASE_TABLE[i].ascii;
        o_hit   = 1'b1;
      end
    end
`ifdef MORSE_PUNCT_EN
    for (int i = 0; i < N_PUNCT; i++) begin
      if (PUNCT_TABLE[i].len == w_len && PUNCT_TABLE[i].pat == w_pat) begin
        o_ascii = PUNCT_TABLE[i].ascii;
        o_hit   = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/morse_stream_decoder.sv
// Morse symbol stream -> ASCII bytes; a character is valid the cycle after its EOL/EOW is taken.
// sym_ready drops while a character waits on out_ready (optional MORSE_PUNCT_EN adds punctuation).
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int MAX_ELEMS = 5,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  morse_stream_decoder_if.slave  bus
);

  localparam int                LEN_W   = $clog2(MAX_ELEMS + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_ELEMS);

  state_t               r_state;
  logic [MAX_ELEMS-1:0] r_pattern;
  logic [LEN_W-1:0]     r_len;
  logic                 r_ovf;
  logic                 r_space_pend;
  logic                 r_last_space;
  logic                 r_out_valid;
  logic [7:0]           r_ascii;
  logic                 r_err;
  logic [CNT_W-1:0]     r_err_cnt;

  logic [7:0] w_lut_ascii;
  logic       w_lut_hit;
  logic       w_sym_acc;
  logic       w_out_acc;
  logic       w_pending;
  logic       w_bad;
  logic [7:0] w_letter_ascii;

  morse_lut #(.MAX_ELEMS(MAX_ELEMS)) u_lut (
    .i_len     (r_len),
    .i_pattern (r_pattern),
    .o_ascii   (w_lut_ascii),
    .o_hit     (w_lut_hit)
  );

  assign w_sym_acc      = bus.sym_valid && (r_state == ST_COLLECT);
  assign w_out_acc      = r_out_valid && bus.out_ready;
  assign w_pending      = (r_len != '0) || r_ovf;
  assign w_bad          = r_ovf || !w_lut_hit;
  assign w_letter_ascii = w_bad ? ASCII_NUL : w_lut_ascii;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_COLLECT;
      r_pattern    <= '0;
      r_len        <= '0;
      r_ovf        <= 1'b0;
      r_space_pend <= 1'b0;
      r_last_space <= 1'b0;
      r_out_valid  <= 1'b0;
      r_ascii      <= ASCII_NUL;
      r_err        <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_sym_acc) begin
            case (bus.sym)
              SYM_DOT, SYM_DASH: begin
                if (r_len < MAX_LEN) begin
                  r_pattern <= {r_pattern[MAX_ELEMS-2:0], bus.sym[0]};
                  r_len     <= r_len + LEN_W'(1);
                end else begin
                  r_ovf <= 1'b1;
                end
              end
              SYM_EOL: begin
                if (w_pending) begin
                  r_ascii     <= w_letter_ascii;
                  r_err       <= w_bad;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_EMIT;
                end
              end
              default: begin
                // End-of-word: flush any letter first, then one space; repeated gaps collapse.
                if (w_pending) begin
                  r_ascii      <= w_letter_ascii;
                  r_err        <= w_bad;
                  r_space_pend <= 1'b1;
                  r_out_valid  <= 1'b1;
                  r_state      <= ST_EMIT;
                end else if (!r_last_space) begin
                  r_ascii     <= ASCII_SPACE;
                  r_err       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_EMIT;
                end
              end
            endcase
          end
        end
        ST_EMIT: begin
          if (w_out_acc) begin
            r_last_space <= (r_ascii == ASCII_SPACE);
            if (r_err && (r_err_cnt != '1)) begin
              r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (r_space_pend) begin
              r_ascii      <= ASCII_SPACE;
              r_err        <= 1'b0;
              r_space_pend <= 1'b0;
            end else begin
              r_len       <= '0;
              r_pattern   <= '0;
              r_ovf       <= 1'b0;
              r_out_valid <= 1'b0;
              r_state     <= ST_COLLECT;
            end
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign bus.sym_ready = (r_state == ST_COLLECT);
  assign bus.out_valid = r_out_valid;
  assign bus.ascii_out = r_ascii;
  assign bus.out_err   = r_err;
  assign bus.err_count = r_err_cnt;

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Bench for morse_stream_decoder: directed scenarios plus randomized text checked
// against a string-keyed Morse reference model.
module tb_morse_stream_decoder;

  localparam int MAX_ELEMS = 5;
  localparam int CNT_W     = 8;
  localparam logic [1:0] DOT = 2'b10, DASH = 2'b11, EOL = 2'b01, EOW = 2'b00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  morse_stream_decoder_if #(.CNT_W(CNT_W)) bus ();

  morse_stream_decoder #(.MAX_ELEMS(MAX_ELEMS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_rdy = 1'b0;

  string codes [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };
  string alnum = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  logic [7:0] tbl [string];

  // Reference model: text-level state, one expected {err, ascii} per emitted character.
  string      m_cur;
  bit         m_ovf;
  bit         m_last_space;
  int         m_errs;
  logic [8:0] exp_q [$];
  logic [8:0] got_q [$];

  always @(negedge clk)
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      got_q.push_back({bus.out_err, bus.ascii_out});

  function automatic void m_reset();
    m_cur = ""; m_ovf = 1'b0; m_last_space = 1'b0; m_errs = 0;
  endfunction

  function automatic void m_push(logic [8:0] v);
    exp_q.push_back(v);
    m_last_space = (v == 9'h020);
    if (v[8]) m_errs++;
  endfunction

  function automatic void m_letter();
    if (m_ovf || !tbl.exists(m_cur)) m_push(9'h100);
    else m_push({1'b0, tbl[m_cur]});
    m_cur = "";
    m_ovf = 1'b0;
  endfunction

  function automatic void m_sym(logic [1:0] s);
    bit pending;
    pending = (m_cur.len() > 0) || m_ovf;
    case (s)
      DOT:  if (m_cur.len() < MAX_ELEMS) m_cur = {m_cur, "."}; else m_ovf = 1'b1;
      DASH: if (m_cur.len() < MAX_ELEMS) m_cur = {m_cur, "-"}; else m_ovf = 1'b1;
      EOL:  if (pending) m_letter();
      default: begin
        if (pending) begin
          m_letter();
          m_push(9'h020);
        end else if (!m_last_space) begin
          m_push(9'h020);
        end
      end
    endcase
  endfunction

  function automatic logic [7:0] m_err_count();
    return (m_errs > 255) ? 8'hFF : 8'(m_errs);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_sym(input logic [1:0] s);
    bit acc = 1'b0;
    int n = 0;
    bus.sym_valid = 1'b1;
    bus.sym = s;
    while (!acc && n < 400) begin
      @(negedge clk);
      acc = (bus.sym_ready === 1'b1);
      tick();
      n++;
    end
    bus.sym_valid = 1'b0;
    if (acc) m_sym(s);
    else begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: sym_ready=%b, want 1 within 400 cycles", bus.sym_ready);
    end
  endtask

  // '.', '-' elements; 'L' end-of-letter; 'W' end-of-word.
  task automatic send_str(input string p);
    for (int i = 0; i < p.len(); i++) begin
      byte c;
      c = p[i];
      if (c == ".") send_sym(DOT);
      else if (c == "-") send_sym(DASH);
      else if (c == "L") send_sym(EOL);
      else send_sym(EOW);
    end
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    ok = 1'b0;
    while (n < 1000 && !ok) begin
      tick();
      n++;
      ok = (got_q.size() >= exp_q.size()) && (bus.out_valid === 1'b0) && (bus.sym_ready === 1'b1);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.sym_ready !== 1'b1) begin n_bad++; $display("FAIL rst_sym_ready: got %b want 1", bus.sym_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.ascii_out !== 8'h00) begin n_bad++; $display("FAIL rst_ascii: got %h want 00", bus.ascii_out); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL rst_out_err: got %b want 0", bus.out_err); end
    n_cmp++; if (bus.err_count !== 8'h00) begin n_bad++; $display("FAIL rst_err_count: got %h want 00", bus.err_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_letter();
    logic [8:0] want [$];
    bit ok;
    want = '{9'h041};
    bus.out_ready = 1'b1;
    send_str(".-");
    send_sym(EOL);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.ascii_out !== 8'h41) begin
      n_bad++;
      $display("FAIL single_latency: out_valid=%b ascii=%h, want 1/41 one cycle after EOL", bus.out_valid, bus.ascii_out);
    end
    drain(ok);
    n_cmp++; if (!ok || got_q.size() != want.size()) begin n_bad++; $display("FAIL single_count: got %0d beats want %0d (drained=%0d)", got_q.size(), want.size(), ok); end
    foreach (want[i]) if (i < got_q.size()) begin
      n_cmp++; if (got_q[i] !== want[i]) begin n_bad++; $display("FAIL single_beat%0d: got %h want %h", i, got_q[i], want[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_length();
    logic [8:0] want [$];
    bit ok;
    want = '{9'h035, 9'h05A};
    send_str(".....L--..L");
    drain(ok);
    n_cmp++; if (!ok || got_q.size() != want.size()) begin n_bad++; $display("FAIL full_count: got %0d beats want %0d (drained=%0d)", got_q.size(), want.size(), ok); end
    foreach (want[i]) if (i < got_q.size()) begin
      n_cmp++; if (got_q[i] !== want[i]) begin n_bad++; $display("FAIL full_beat%0d: got %h want %h", i, got_q[i], want[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [8:0] want [$];
    bit ok;
    want = '{9'h100, 9'h045};
    send_str("......L");
    drain(ok);
    n_cmp++; if (bus.err_count !== 8'd1) begin n_bad++; $display("FAIL ovf_err_count: got %0d want 1", bus.err_count); end
    send_str(".L");
    drain(ok);
    n_cmp++; if (!ok || got_q.size() != want.size()) begin n_bad++; $display("FAIL ovf_count: got %0d beats want %0d (drained=%0d)", got_q.size(), want.size(), ok); end
    foreach (want[i]) if (i < got_q.size()) begin
      n_cmp++; if (got_q[i] !== want[i]) begin n_bad++; $display("FAIL ovf_beat%0d: got %h want %h", i, got_q[i], want[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_word_gaps();
    logic [8:0] want [$];
    bit ok;
    want = '{9'h045, 9'h020, 9'h054};
    send_str(".WWW-L");
    drain(ok);
    n_cmp++; if (!ok || got_q.size() != want.size()) begin n_bad++; $display("FAIL gap_count: got %0d beats want %0d (drained=%0d)", got_q.size(), want.size(), ok); end
    foreach (want[i]) if (i < got_q.size()) begin
      n_cmp++; if (got_q[i] !== want[i]) begin n_bad++; $display("FAIL gap_beat%0d: got %h want %h", i, got_q[i], want[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.out_ready = 1'b0;
    send_str("..L");
    bus.sym_valid = 1'b1;
    bus.sym = DOT;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.ascii_out !== 8'h49 || bus.out_err !== 1'b0 || bus.sym_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: valid=%b ascii=%h err=%b sym_ready=%b, want 1/49/0/0", c, bus.out_valid, bus.ascii_out, bus.out_err, bus.sym_ready);
      end
      tick();
    end
    bus.sym_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (got_q.size() != 1 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: beats=%0d out_valid=%b, want 1 beat then valid 0", got_q.size(), bus.out_valid);
    end
    drain(ok);
    n_cmp++; if (!ok || got_q.size() != 1 || got_q[0] !== 9'h049) begin n_bad++; $display("FAIL bp_beat: got %0d beats first %h want 1 beat 049", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h1FF); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_text();
    bit ok;
    int mism = 0;
    rand_rdy = 1'b1;
    for (int w = 0; w < 30; w++) begin
      int nl;
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) begin
        string code;
        if ($urandom_range(0, 5) == 0) begin
          code = "";
          repeat ($urandom_range(1, 7)) begin
            if ($urandom_range(0, 1) != 0) code = {code, "-"};
            else code = {code, "."};
          end
        end else begin
          code = codes[$urandom_range(0, 35)];
        end
        send_str(code);
        send_sym((l == nl - 1) ? EOW : EOL);
        if ($urandom_range(0, 7) == 0) send_sym(EOL);
      end
      if ($urandom_range(0, 3) == 0) send_sym(EOW);
    end
    drain(ok);
    n_cmp++; if (!ok || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d beats want %0d (drained=%0d)", got_q.size(), exp_q.size(), ok); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        if (mism++ < 8) $display("FAIL rand_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (bus.err_count !== m_err_count()) begin n_bad++; $display("FAIL rand_err_count: got %0d want %0d", bus.err_count, m_err_count()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    string bad [5] = '{"......", "..--", ".-.-", "---.", "----"};
    bit ok;
    int n_err = 0;
    for (int k = 0; k < 300; k++) begin
      send_str(bad[$urandom_range(0, 4)]);
      send_sym(EOL);
    end
    drain(ok);
    foreach (got_q[i]) if (got_q[i] === 9'h100) n_err++;
    n_cmp++; if (!ok || n_err != 300) begin n_bad++; $display("FAIL sat_beats: got %0d invalid beats want 300 (drained=%0d)", n_err, ok); end
    n_cmp++; if (bus.err_count !== 8'hFF) begin n_bad++; $display("FAIL sat_err_count: got %0d want 255", bus.err_count); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midway();
    bit ok;
    logic [8:0] want [$];
    bus.out_ready = 1'b1;
    send_str(".-");
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({bus.sym_ready, bus.out_valid, bus.out_err, bus.ascii_out, bus.err_count} !== {3'b100, 8'h00, 8'h00}) begin
      n_bad++;
      $display("FAIL mid_letter_rst: rdy=%b vld=%b err=%b ascii=%h cnt=%h, want 1/0/0/00/00",
               bus.sym_ready, bus.out_valid, bus.out_err, bus.ascii_out, bus.err_count);
    end
    m_reset();
    tick();
    rst_n = 1'b1;
    send_sym(EOL);
    repeat (4) tick();
    n_cmp++; if (got_q.size() != 0 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_letter_eol: beats=%0d out_valid=%b, want 0/0", got_q.size(), bus.out_valid); end
    bus.out_ready = 1'b0;
    send_str(".W");
    rst_n = 1'b0;
    #2;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.sym_ready !== 1'b1) begin n_bad++; $display("FAIL mid_emit_rst: out_valid=%b sym_ready=%b, want 0/1", bus.out_valid, bus.sym_ready); end
    m_reset();
    got_q.delete(); exp_q.delete();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    want = '{9'h054};
    send_str("-L");
    drain(ok);
    n_cmp++; if (!ok || got_q.size() != 1 || got_q[0] !== want[0]) begin n_bad++; $display("FAIL mid_emit_after: got %0d beats first %h want 1 beat 054", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h1FF); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym = EOW;
    bus.out_ready = 1'b1;
    foreach (codes[i]) tbl[codes[i]] = alnum[i];
    m_reset();
    test_reset();
    test_single_letter();
    test_full_length();
    test_overflow();
    test_word_gaps();
    test_backpressure();
    test_random_text();
    test_saturation();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
